id_ex_stage: RTL and testbench

- ID/EX pipeline register for the RV32I 5-stage pipeline; captures register-file read data, immediate, PC and decoded control from ID and presents them to EX.
- Contains the load-use hazard detector (stall + bubble insertion) and a WB->ID bypass. The bypass is needed because the register file writes on negedge and its read port does not re-evaluate on a same-address write.
- Honors a branch/jump flush from EX.

---
 rtl/id_ex_stage_if.sv | 44 ++++
 rtl/id_ex_stage.sv | 117 +++++++++++
 tb/tb_id_ex_stage.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: ID-side operands/control, WB bypass source, EX flush, and the
// registered EX-side copies plus the load-use stall back to IF/ID.
interface id_ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 9
);
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [XLEN-1:0]   id_rdata_a;
  logic [XLEN-1:0]   id_rdata_b;
  logic [XLEN-1:0]   id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              wb_reg_write;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              flush;
  logic              stall_o;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [4:0]        ex_rd;
  logic [XLEN-1:0]   ex_a;
  logic [XLEN-1:0]   ex_b;
  logic [XLEN-1:0]   ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_rdata_a, id_rdata_b, id_imm, id_ctrl, wb_reg_write, wb_rd, wb_data, flush,
    output stall_o, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_a, ex_b, ex_imm, ex_ctrl
  );

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_rdata_a, id_rdata_b, id_imm, id_ctrl, wb_reg_write, wb_rd, wb_data, flush,
    input  stall_o, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_a, ex_b, ex_imm, ex_ctrl
  );
endinterface

// File: rtl/id_ex_stage.sv
// RV32I ID/EX pipeline register with load-use stall/bubble, WB->ID bypass and EX flush.
// Optional stall/flush counters are built when IDEX_PERF_CNT_EN is defined.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 9
) (
  input  logic clk,
  input  logic rst,
  id_ex_stage_if.slave bus
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  logic              ex_valid_r;
  logic [XLEN-1:0]   ex_pc_r;
  logic [4:0]        ex_rs1_r;
  logic [4:0]        ex_rs2_r;
  logic [4:0]        ex_rd_r;
  logic [XLEN-1:0]   ex_a_r;
  logic [XLEN-1:0]   ex_b_r;
  logic [XLEN-1:0]   ex_imm_r;
  logic [CTRL_W-1:0] ex_ctrl_r;

  logic              hit_rs1_s;
  logic              hit_rs2_s;
  logic              stall_s;
  logic [XLEN-1:0]   a_in_s;
  logic [XLEN-1:0]   b_in_s;

  // Load-use detector: a load in EX feeding the ID instruction; a flush kills ID so no stall.
  always_comb begin
    hit_rs1_s = bus.id_use_rs1 && (bus.id_rs1 == ex_rd_r);
    hit_rs2_s = bus.id_use_rs2 && (bus.id_rs2 == ex_rd_r);
    stall_s   = bus.id_valid && ex_valid_r && ex_ctrl_r[1] && (ex_rd_r != 5'd0) &&
                (hit_rs1_s || hit_rs2_s) && !bus.flush;
  end

  // WB bypass: the regfile read port misses a same-cycle negedge write, so forward it here.
  always_comb begin
    if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.id_rs1)) begin
      a_in_s = bus.wb_data;
    end else begin
      a_in_s = bus.id_rdata_a;
    end
    if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.id_rs2)) begin
      b_in_s = bus.wb_data;
    end else begin
      b_in_s = bus.id_rdata_b;
    end
  end

  // Pipeline register: flush and stall both insert a bubble and hold the data fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_r <= 1'b0;
      ex_pc_r    <= {XLEN{1'b0}};
      ex_rs1_r   <= 5'd0;
      ex_rs2_r   <= 5'd0;
      ex_rd_r    <= 5'd0;
      ex_a_r     <= {XLEN{1'b0}};
      ex_b_r     <= {XLEN{1'b0}};
      ex_imm_r   <= {XLEN{1'b0}};
      ex_ctrl_r  <= {CTRL_W{1'b0}};
    end else if (bus.flush || stall_s) begin
      ex_valid_r <= 1'b0;
      ex_ctrl_r  <= {CTRL_W{1'b0}};
    end else begin
      ex_valid_r <= bus.id_valid;
      ex_ctrl_r  <= bus.id_valid ? bus.id_ctrl : {CTRL_W{1'b0}};
      ex_pc_r    <= bus.id_pc;
      ex_rs1_r   <= bus.id_rs1;
      ex_rs2_r   <= bus.id_rs2;
      ex_rd_r    <= bus.id_rd;
      ex_a_r     <= a_in_s;
      ex_b_r     <= b_in_s;
      ex_imm_r   <= bus.id_imm;
    end
  end

  assign bus.stall_o  = stall_s;
  assign bus.ex_valid = ex_valid_r;
  assign bus.ex_pc    = ex_pc_r;
  assign bus.ex_rs1   = ex_rs1_r;
  assign bus.ex_rs2   = ex_rs2_r;
  assign bus.ex_rd    = ex_rd_r;
  assign bus.ex_a     = ex_a_r;
  assign bus.ex_b     = ex_b_r;
  assign bus.ex_imm   = ex_imm_r;
  assign bus.ex_ctrl  = ex_ctrl_r;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  // Event counters; natural 32-bit wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (stall_s) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
      if (bus.flush) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven scoreboard bench for id_ex_stage; define IDEX_PERF_CNT_EN to cover the counters.
module tb_id_ex_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  id_ex_stage_if #(.XLEN(32), .CTRL_W(9)) bus ();

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  id_ex_stage #(.XLEN(32), .CTRL_W(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IDEX_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2;
    logic [31:0] ra, rb, imm;
    logic [8:0]  ctrl;
    logic        wbw;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        fl;
    logic        e_stall;
    logic        e_valid;
    logic [8:0]  e_ctrl;
    logic [31:0] e_a, e_b;
    logic        e_data;
  } vec_t;

  typedef struct {
    string       tag;
    logic        e_data;
    logic        valid;
    logic [8:0]  ctrl;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] a, b, imm;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[13];

  function automatic vec_t mk(
    input logic valid, input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [4:0] rd, input logic u1, input logic u2, input logic [31:0] ra,
    input logic [31:0] rb, input logic [31:0] imm, input logic [8:0] ctrl, input logic wbw,
    input logic [4:0] wbrd, input logic [31:0] wbd, input logic fl, input logic e_stall,
    input logic e_valid, input logic [8:0] e_ctrl, input logic [31:0] e_a,
    input logic [31:0] e_b, input logic e_data);
    vec_t v;
    v.valid = valid; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.u1 = u1; v.u2 = u2;
    v.ra = ra; v.rb = rb; v.imm = imm; v.ctrl = ctrl; v.wbw = wbw; v.wbrd = wbrd; v.wbd = wbd;
    v.fl = fl; v.e_stall = e_stall; v.e_valid = e_valid; v.e_ctrl = e_ctrl;
    v.e_a = e_a; v.e_b = e_b; v.e_data = e_data;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.id_valid     = v.valid;
    bus.id_pc        = v.pc;
    bus.id_rs1       = v.rs1;
    bus.id_rs2       = v.rs2;
    bus.id_rd        = v.rd;
    bus.id_use_rs1   = v.u1;
    bus.id_use_rs2   = v.u2;
    bus.id_rdata_a   = v.ra;
    bus.id_rdata_b   = v.rb;
    bus.id_imm       = v.imm;
    bus.id_ctrl      = v.ctrl;
    bus.wb_reg_write = v.wbw;
    bus.wb_rd        = v.wbrd;
    bus.wb_data      = v.wbd;
    bus.flush        = v.fl;
  endtask

  // Drive at negedge, check stall before the edge, score the registered result after it.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    drive(v);
    #1;
    check({tag, " stall_o"}, 32'(bus.stall_o), 32'(v.e_stall));
    e.tag = tag; e.e_data = v.e_data; e.valid = v.e_valid; e.ctrl = v.e_ctrl;
    e.pc = v.pc; e.rs1 = v.rs1; e.rs2 = v.rs2; e.rd = v.rd;
    e.a = v.e_a; e.b = v.e_b; e.imm = v.imm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, " scoreboard"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, " ex_valid"}, 32'(bus.ex_valid), 32'(e.valid));
      check({e.tag, " ex_ctrl"}, 32'(bus.ex_ctrl), 32'(e.ctrl));
      if (e.e_data) begin
        check({e.tag, " ex_pc"}, bus.ex_pc, e.pc);
        check({e.tag, " ex_rs1"}, 32'(bus.ex_rs1), 32'(e.rs1));
        check({e.tag, " ex_rs2"}, 32'(bus.ex_rs2), 32'(e.rs2));
        check({e.tag, " ex_rd"}, 32'(bus.ex_rd), 32'(e.rd));
        check({e.tag, " ex_a"}, bus.ex_a, e.a);
        check({e.tag, " ex_b"}, bus.ex_b, e.b);
        check({e.tag, " ex_imm"}, bus.ex_imm, e.imm);
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " ex_valid"}, 32'(bus.ex_valid), 32'd0);
    check({tag, " ex_ctrl"}, 32'(bus.ex_ctrl), 32'd0);
    check({tag, " ex_pc"}, bus.ex_pc, 32'd0);
    check({tag, " ex_rd"}, 32'(bus.ex_rd), 32'd0);
    check({tag, " ex_a"}, bus.ex_a, 32'd0);
    check({tag, " ex_b"}, bus.ex_b, 32'd0);
    check({tag, " ex_imm"}, bus.ex_imm, 32'd0);
    check({tag, " stall_o"}, 32'(bus.stall_o), 32'd0);
  endtask

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(mk(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 9'd0,
             1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 1'b0));

    //            valid pc       rs1   rs2   rd     u1    u2    ra             rb            imm            ctrl     wbw   wbrd  wbd             fl    st    ev    ectrl    e_a            e_b           data
    vecs[0]  = mk(1'b1, 32'h40, 5'd3, 5'd4, 5'd1,  1'b1, 1'b1, 32'h11,        32'h22,       32'hFFFFFFF0,  9'h001, 1'b0, 5'd0, 32'd0,          1'b0, 1'b0, 1'b1, 9'h001,  32'h11,        32'h22,       1'b1);
    vecs[1]  = mk(1'b1, 32'h44, 5'd2, 5'd0, 5'd5,  1'b1, 1'b0, 32'h100,       32'h0,        32'h8,         9'h00B, 1'b0, 5'd0, 32'd0,          1'b0, 1'b0, 1'b1, 9'h00B,  32'h100,       32'h0,        1'b1);
    vecs[2]  = mk(1'b1, 32'h48, 5'd6, 5'd5, 5'd8,  1'b1, 1'b1, 32'h3,         32'h9,        32'h0,         9'h001, 1'b0, 5'd0, 32'd0,          1'b0, 1'b1, 1'b0, 9'h000,  32'h0,         32'h0,        1'b0);
    vecs[3]  = mk(1'b1, 32'h48, 5'd6, 5'd5, 5'd8,  1'b1, 1'b1, 32'h3,         32'h9,        32'h0,         9'h001, 1'b0, 5'd0, 32'd0,          1'b0, 1'b0, 1'b1, 9'h001,  32'h3,         32'h9,        1'b1);
    vecs[4]  = mk(1'b1, 32'h4C, 5'd2, 5'd0, 5'd0,  1'b1, 1'b0, 32'h100,       32'h0,        32'h4,         9'h00B, 1'b0, 5'd0, 32'd0,          1'b0, 1'b0, 1'b1, 9'h00B,  32'h100,       32'h0,        1'b1);
    vecs[5]  = mk(1'b1, 32'h50, 5'd0, 5'd0, 5'd9,  1'b1, 1'b1, 32'h0,         32'h0,        32'h0,         9'h001, 1'b0, 5'd0, 32'd0,          1'b0, 1'b0, 1'b1, 9'h001,  32'h0,         32'h0,        1'b1);
    vecs[6]  = mk(1'b1, 32'h54, 5'd7, 5'd1, 5'd10, 1'b1, 1'b1, 32'h0,         32'h55,       32'h0,         9'h001, 1'b1, 5'd7, 32'hDEADBEEF,   1'b0, 1'b0, 1'b1, 9'h001,  32'hDEADBEEF,  32'h55,       1'b1);
    vecs[7]  = mk(1'b1, 32'h58, 5'd0, 5'd7, 5'd11, 1'b1, 1'b1, 32'h12,        32'h34,       32'h0,         9'h001, 1'b1, 5'd0, 32'hCAFEF00D,   1'b0, 1'b0, 1'b1, 9'h001,  32'h12,        32'h34,       1'b1);
    vecs[8]  = mk(1'b1, 32'h5C, 5'd2, 5'd0, 5'd5,  1'b1, 1'b0, 32'h200,       32'h0,        32'h0,         9'h00B, 1'b0, 5'd0, 32'd0,          1'b0, 1'b0, 1'b1, 9'h00B,  32'h200,       32'h0,        1'b1);
    vecs[9]  = mk(1'b1, 32'h60, 5'd5, 5'd6, 5'd12, 1'b1, 1'b1, 32'h1,         32'h2,        32'h0,         9'h001, 1'b0, 5'd0, 32'd0,          1'b1, 1'b0, 1'b0, 9'h000,  32'h0,         32'h0,        1'b0);
    vecs[10] = mk(1'b1, 32'h64, 5'd2, 5'd0, 5'd5,  1'b1, 1'b0, 32'h300,       32'h0,        32'h0,         9'h00B, 1'b0, 5'd0, 32'd0,          1'b0, 1'b0, 1'b1, 9'h00B,  32'h300,       32'h0,        1'b1);
    vecs[11] = mk(1'b0, 32'h68, 5'd5, 5'd0, 5'd3,  1'b1, 1'b0, 32'hAA,        32'hBB,       32'h7,         9'h1FF, 1'b0, 5'd0, 32'd0,          1'b0, 1'b0, 1'b0, 9'h000,  32'hAA,        32'hBB,       1'b1);
    vecs[12] = mk(1'b1, 32'h6C, 5'd5, 5'd0, 5'd5,  1'b1, 1'b0, 32'hA5A5A5A5,  32'h5A5A5A5A, 32'h80000000,  9'h1FF, 1'b0, 5'd0, 32'd0,          1'b0, 1'b0, 1'b1, 9'h1FF,  32'hA5A5A5A5,  32'h5A5A5A5A, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    check_reset_state("por");
`ifdef IDEX_PERF_CNT_EN
    check("por stall_cnt", stall_cnt, 32'd0);
    check("por flush_cnt", flush_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i], $sformatf("row%0d", i));
    end

    // EX now holds ctrl 0x1FF (a load) to x5; create a live stall, then reset mid-cycle.
    @(negedge clk);
    v = vecs[3];
    v.rs1 = 5'd5;
    drive(v);
    #1;
    check("pre-rst stall_o", 32'(bus.stall_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    rst = 1'b0;

`ifdef IDEX_PERF_CNT_EN
    check("postrst stall_cnt", stall_cnt, 32'd0);
    check("postrst flush_cnt", flush_cnt, 32'd0);
    for (int k = 0; k < 3; k++) begin
      apply(vecs[1], $sformatf("perf%0d lw", k));
      apply(vecs[2], $sformatf("perf%0d haz", k));
      apply(vecs[3], $sformatf("perf%0d add", k));
    end
    v = vecs[0];
    v.fl = 1'b1; v.e_valid = 1'b0; v.e_ctrl = 9'h000; v.e_data = 1'b0;
    apply(v, "perf flush0");
    apply(v, "perf flush1");
    check("perf stall_cnt", stall_cnt, 32'd3);
    check("perf flush_cnt", flush_cnt, 32'd2);
    apply(vecs[1], "wrap lw");
    force dut.stall_cnt_r = 32'hFFFFFFFF;
    #1;
    release dut.stall_cnt_r;
    check("wrap preload", stall_cnt, 32'hFFFFFFFF);
    apply(vecs[2], "wrap haz");
    check("wrap stall_cnt", stall_cnt, 32'd0);
    check("wrap flush_cnt", flush_cnt, 32'd2);
`endif

    if (sb.size() != 0) begin
      check("scoreboard drain", 32'(sb.size()), 32'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
